key_entry_ctrl: RTL and testbench
=================================

Name: key_entry_ctrl

Overview:
Sequences PS/2 keyboard input into numeric entries (account number, PIN, single menu key) for the ATM FSM. It sits between the PS/2 receiver byte stream and the FSM/user_input layer. The FSM requests an entry with a mode; the block filters break and extended prefixes, decodes digits, handles backspace, enter, escape and inactivity timeout, then returns the BCD value with a one-cycle done strobe and a status code.

Parameters:
MAX_DIGITS, 4, digit capacity for ACC_NUMBER/PIN_NUMBER entries (1..4)
TIMEOUT_CYCLES, 32'd3_000_000_000, idle cycles in COLLECT before abort (30 s at 100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous reset, active-high
scan_valid  in  1  one-cycle strobe: new byte on scan_byte
scan_byte  in  8  PS/2 set-2 byte (make, 0xF0 break prefix, 0xE0 extended prefix)
start  in  1  one-cycle request from FSM to begin an entry
mode  in  4  input style, sampled on start: SINGLE_KEY=4'b0001, ACC_NUMBER=4'b0010, PIN_NUMBER=4'b0011
busy  out  1  high from the cycle after start until done
digit_count  out  3  digits currently held (0..MAX_DIGITS)
value  out  16  BCD digits, most recent digit in [3:0]
done  out  1  one-cycle completion strobe
status  out  4  valid with done: INPUT_COMPLETE=4'b1000, EXIT=4'b0111
timed_out  out  1  valid with done: 1 if EXIT was caused by timeout

Behaviour:
- Reset, asynchronous: state=IDLE; busy=0, digit_count=0, value=0, done=0, status=0, timed_out=0, timer=0, prefix flags cleared. Reset mid-entry aborts the entry without a done strobe.
- States: IDLE, COLLECT, SKIP_BREAK, EXT, DONE.
- IDLE: start latches mode, clears value, digit_count and timer, and moves to COLLECT. busy=1 from the next cycle.
- Any mode other than the three listed completes on the next cycle with status=EXIT.
- COLLECT, on scan_valid:
  - 0xF0: go to SKIP_BREAK.
  - 0xE0: go to EXT.
  - Otherwise decode the make code.
- SKIP_BREAK: the next scan_valid byte is discarded, then return to COLLECT.
- EXT: next byte 0x5A (keypad enter) is treated as Enter. Next byte 0xF0 goes to SKIP_BREAK. Any other byte is discarded. Then return to COLLECT.
- Digit make codes: 0=0x45, 1=0x16, 2=0x1E, 3=0x26, 4=0x25, 5=0x2E, 6=0x36, 7=0x3D, 8=0x3E, 9=0x46.
  - A digit does value <= {value[11:0], d} and digit_count+1.
  - If digit_count==MAX_DIGITS the digit is ignored.
  - Typematic repeats are accepted as new digits.
- Backspace 0x66: value <= {4'h0, value[15:4]}, digit_count-1. Ignored when digit_count==0.
- Escape 0x76: complete with status=EXIT. value and digit_count are held.
- Enter 0x5A:
  - ACC_NUMBER: completes if digit_count>=1.
  - PIN_NUMBER: completes only if digit_count==MAX_DIGITS.
  - Otherwise Enter is ignored.
- SINGLE_KEY: the first digit completes the entry immediately with INPUT_COMPLETE. Enter is ignored. Escape gives EXIT.
- Unrecognised make codes are ignored.
- Timer:
  - Counts cycles in COLLECT, SKIP_BREAK and EXT.
  - Clears on every scan_valid.
  - On reaching TIMEOUT_CYCLES-1: complete with status=EXIT and timed_out=1.
  - If scan_valid arrives in the same cycle as the timeout, the byte is processed and the timer clears; no timeout fires.
- Completion: enter DONE on the cycle after the terminating byte. done=1 for exactly that cycle, status and timed_out are driven, busy falls with done. Then go to IDLE.
- value, status and digit_count hold until the next start.
- start while busy is ignored. start in the DONE cycle is ignored. scan_valid in IDLE or DONE is ignored.
- Latency: terminating byte to done is 1 cycle.

Decomposition:
- Shared package (atm_pkg) holds:
  - status codes (ACC_FOUND..INPUT_COMPLETE);
  - input-style codes (SINGLE_KEY..CURRENCY_AMOUNT);
  - top-level ATM state encodings;
  - scan-code constants (digits, ENTER, BKSP, ESC, BREAK_PFX, EXT_PFX).
  The same constants are used by user_input and FSM.
- One natural sub-module, scan_digit_decode: combinational, scan byte -> {is_digit, digit[3:0]}.

Test Plan:
- ACC_NUMBER: start, bytes 16 F0 16 1E F0 1E 5A -> done=1 once, status=4'b1000, value=16'h0012, digit_count=2.
- PIN_NUMBER, MAX_DIGITS=4:
  - 16 1E 26 then 5A -> Enter ignored, busy stays 1.
  - Then 25 5A -> value=16'h1234, INPUT_COMPLETE.
  - Fifth digit 2E before Enter -> ignored, value stays 16'h1234.
- Backspace: 16 1E 66 26 5A in ACC mode -> value=16'h0013, digit_count=2. 66 with 0 digits -> digit_count stays 0.
- Prefixes: E0 5A after digit 45 -> completes with value=16'h0000, digit_count=1. Byte sequence E0 F0 5A -> no completion.
- Escape and timeout (TIMEOUT_CYCLES=50):
  - 76 -> status=4'b0111, timed_out=0.
  - No bytes for 50 cycles -> done, status=4'b0111, timed_out=1.
  - A byte at cycle 49 -> no timeout.
- Reset and start edge cases:
  - rst asserted mid-entry -> all outputs 0 immediately, no done.
  - start during busy -> ignored.
  - SINGLE_KEY with byte 3E -> done next cycle, value=16'h0008.

Source files
------------

// File: rtl/atm_pkg.sv
// Constants shared by the ATM controller, user_input and key_entry_ctrl:
// status codes, input styles, top-level states and PS/2 set-2 scan codes.
package atm_pkg;

  // Status codes returned to the ATM FSM
  localparam logic [3:0] ACC_FOUND      = 4'b0001;
  localparam logic [3:0] ACC_NOT_FOUND  = 4'b0010;
  localparam logic [3:0] PIN_CORRECT    = 4'b0011;
  localparam logic [3:0] PIN_WRONG      = 4'b0100;
  localparam logic [3:0] BALANCE_OK     = 4'b0101;
  localparam logic [3:0] NO_FUNDS       = 4'b0110;
  localparam logic [3:0] EXIT           = 4'b0111;
  localparam logic [3:0] INPUT_COMPLETE = 4'b1000;

  // Input styles requested by the FSM
  localparam logic [3:0] SINGLE_KEY      = 4'b0001;
  localparam logic [3:0] ACC_NUMBER      = 4'b0010;
  localparam logic [3:0] PIN_NUMBER      = 4'b0011;
  localparam logic [3:0] CURRENCY_AMOUNT = 4'b0100;

  typedef enum logic [3:0] {
    ATM_IDLE,
    ATM_ACC_ENTRY,
    ATM_PIN_ENTRY,
    ATM_MENU,
    ATM_BALANCE,
    ATM_WITHDRAW,
    ATM_DEPOSIT,
    ATM_EXIT
  } atm_state_t;

  typedef enum logic [2:0] {
    KE_IDLE,
    KE_COLLECT,
    KE_SKIP_BREAK,
    KE_EXT,
    KE_DONE
  } key_state_t;

  // PS/2 set-2 make codes
  localparam logic [7:0] KEY_0     = 8'h45;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_3     = 8'h26;
  localparam logic [7:0] KEY_4     = 8'h25;
  localparam logic [7:0] KEY_5     = 8'h2E;
  localparam logic [7:0] KEY_6     = 8'h36;
  localparam logic [7:0] KEY_7     = 8'h3D;
  localparam logic [7:0] KEY_8     = 8'h3E;
  localparam logic [7:0] KEY_9     = 8'h46;
  localparam logic [7:0] ENTER     = 8'h5A;
  localparam logic [7:0] BKSP      = 8'h66;
  localparam logic [7:0] ESC       = 8'h76;
  localparam logic [7:0] BREAK_PFX = 8'hF0;
  localparam logic [7:0] EXT_PFX   = 8'hE0;

endpackage

// File: rtl/scan_digit_decode.sv
// Maps a PS/2 set-2 make code onto a decimal digit; is_digit flags a hit.
module scan_digit_decode
  import atm_pkg::*;
(
  input  logic [7:0] scan_byte,
  output logic       is_digit,
  output logic [3:0] digit
);

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (scan_byte)
      KEY_0:   digit = 4'd0;
      KEY_1:   digit = 4'd1;
      KEY_2:   digit = 4'd2;
      KEY_3:   digit = 4'd3;
      KEY_4:   digit = 4'd4;
      KEY_5:   digit = 4'd5;
      KEY_6:   digit = 4'd6;
      KEY_7:   digit = 4'd7;
      KEY_8:   digit = 4'd8;
      KEY_9:   digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// Turns the PS/2 byte stream into account/PIN/menu entries for the ATM FSM,
// returning BCD digits with a one-cycle done strobe and a status code.
module key_entry_ctrl
  import atm_pkg::*;
#(
  parameter int          MAX_DIGITS     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3_000_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_valid,
  input  logic [7:0]  scan_byte,
  input  logic        start,
  input  logic [3:0]  mode,
  output logic        busy,
  output logic [2:0]  digit_count,
  output logic [15:0] value,
  output logic        done,
  output logic [3:0]  status,
  output logic        timed_out
);

  localparam logic [2:0] MAX_COUNT = 3'(MAX_DIGITS);

  key_state_t  state_reg, state_next;
  logic [3:0]  mode_reg, mode_next;
  logic [15:0] value_reg, value_next;
  logic [2:0]  count_reg, count_next;
  logic [31:0] timer_reg, timer_next;
  logic [3:0]  status_reg, status_next;
  logic        timed_out_reg, timed_out_next;
  logic        key_press;
  logic        is_digit;
  logic [3:0]  digit;

  scan_digit_decode u_decode (
    .scan_byte (scan_byte),
    .is_digit  (is_digit),
    .digit     (digit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= KE_IDLE;
      mode_reg      <= '0;
      value_reg     <= '0;
      count_reg     <= '0;
      timer_reg     <= '0;
      status_reg    <= '0;
      timed_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      value_reg     <= value_next;
      count_reg     <= count_next;
      timer_reg     <= timer_next;
      status_reg    <= status_next;
      timed_out_reg <= timed_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    value_next     = value_reg;
    count_next     = count_reg;
    timer_next     = timer_reg;
    status_next    = status_reg;
    timed_out_next = timed_out_reg;
    key_press      = 1'b0;

    case (state_reg)
      KE_IDLE: begin
        if (start) begin
          mode_next      = mode;
          value_next     = '0;
          count_next     = '0;
          timer_next     = '0;
          status_next    = '0;
          timed_out_next = 1'b0;
          if (mode == SINGLE_KEY || mode == ACC_NUMBER || mode == PIN_NUMBER) begin
            state_next = KE_COLLECT;
          end else begin
            state_next  = KE_DONE;
            status_next = EXIT;
          end
        end
      end

      KE_COLLECT, KE_SKIP_BREAK, KE_EXT: begin
        if (scan_valid) begin
          // A byte always restarts the idle timer, even in the timeout cycle
          timer_next = '0;
          state_next = KE_COLLECT;
          if (state_reg == KE_COLLECT) begin
            if (scan_byte == BREAK_PFX)    state_next = KE_SKIP_BREAK;
            else if (scan_byte == EXT_PFX) state_next = KE_EXT;
            else                           key_press = 1'b1;
          end else if (state_reg == KE_EXT) begin
            if (scan_byte == BREAK_PFX)    state_next = KE_SKIP_BREAK;
            else if (scan_byte == ENTER)   key_press = 1'b1;
          end

          if (key_press) begin
            if (is_digit) begin
              if (count_reg < MAX_COUNT) begin
                value_next = {value_reg[11:0], digit};
                count_next = count_reg + 3'd1;
                if (mode_reg == SINGLE_KEY) begin
                  state_next  = KE_DONE;
                  status_next = INPUT_COMPLETE;
                end
              end
            end else if (scan_byte == BKSP) begin
              if (count_reg != 3'd0) begin
                value_next = {4'h0, value_reg[15:4]};
                count_next = count_reg - 3'd1;
              end
            end else if (scan_byte == ESC) begin
              state_next  = KE_DONE;
              status_next = EXIT;
            end else if (scan_byte == ENTER) begin
              if ((mode_reg == ACC_NUMBER && count_reg != 3'd0) ||
                  (mode_reg == PIN_NUMBER && count_reg == MAX_COUNT)) begin
                state_next  = KE_DONE;
                status_next = INPUT_COMPLETE;
              end
            end
          end
        end else if (timer_reg == TIMEOUT_CYCLES - 32'd1) begin
          state_next     = KE_DONE;
          status_next    = EXIT;
          timed_out_next = 1'b1;
        end else begin
          timer_next = timer_reg + 32'd1;
        end
      end

      KE_DONE: state_next = KE_IDLE;

      default: state_next = KE_IDLE;
    endcase
  end

  assign busy        = (state_reg == KE_COLLECT) || (state_reg == KE_SKIP_BREAK) ||
                       (state_reg == KE_EXT);
  assign done        = (state_reg == KE_DONE);
  assign digit_count = count_reg;
  assign value       = value_reg;
  assign status      = status_reg;
  assign timed_out   = timed_out_reg;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: table-driven entries, hand-written
// timeout/reset/start corner cases, and random traffic against a digit-queue model.
module tb_key_entry_ctrl;

  localparam int          MAXD = 4;
  localparam logic [31:0] TO   = 32'd50;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_valid;
  logic [7:0]  scan_byte;
  logic        start;
  logic [3:0]  mode;
  logic        busy;
  logic [2:0]  digit_count;
  logic [15:0] value;
  logic        done;
  logic [3:0]  status;
  logic        timed_out;

  int checks   = 0;
  int failures = 0;

  key_entry_ctrl #(.MAX_DIGITS(MAXD), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_valid  (scan_valid),
    .scan_byte   (scan_byte),
    .start       (start),
    .mode        (mode),
    .busy        (busy),
    .digit_count (digit_count),
    .value       (value),
    .done        (done),
    .status      (status),
    .timed_out   (timed_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_byte  = b;
    step();
    scan_valid = 1'b0;
  endtask

  task automatic begin_entry(input logic [3:0] m);
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ---------------- table of whole entries ----------------
  typedef struct {
    string       name;
    logic [3:0]  mode;
    int          n;
    logic [63:0] seq;        // n bytes, first byte most significant
    bit          exp_done;
    logic [3:0]  exp_status;
    logic [15:0] exp_value;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[13];

  // ---------------- behavioural reference model ----------------
  int          m_phase;      // 0 waiting for start, 1 entry open, 2 done strobe
  logic [3:0]  m_mode;
  logic [3:0]  m_status;
  bit          m_to;
  int          m_idle;
  bit          m_skip, m_ext;
  logic [3:0]  q[$];
  logic [7:0]  digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0]  pool[18] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                            8'h3D, 8'h3E, 8'h46, 8'hF0, 8'hE0, 8'h5A, 8'h66,
                            8'h76, 8'h5A, 8'h1C, 8'h12};

  function automatic logic [15:0] model_value();
    logic [15:0] v = 16'h0;
    foreach (q[i]) v = {v[11:0], q[i]};
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_mode = 4'h0; m_status = 4'h0; m_to = 1'b0;
    m_idle = 0; m_skip = 1'b0; m_ext = 1'b0;
    q.delete();
  endtask

  task automatic model_finish(input logic [3:0] st, input bit to);
    m_phase  = 2;
    m_status = st;
    m_to     = to;
  endtask

  task automatic model_key(input logic [7:0] b);
    int d = -1;
    for (int i = 0; i < 10; i++) if (digit_codes[i] == b) d = i;
    if (d >= 0) begin
      if (q.size() < MAXD) begin
        q.push_back(4'(d));
        if (m_mode == 4'd1) model_finish(4'b1000, 1'b0);
      end
    end else if (b == 8'h66) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (b == 8'h76) begin
      model_finish(4'b0111, 1'b0);
    end else if (b == 8'h5A) begin
      if ((m_mode == 4'd2 && q.size() >= 1) || (m_mode == 4'd3 && q.size() == MAXD))
        model_finish(4'b1000, 1'b0);
    end
  endtask

  task automatic model_cycle(input bit st, input logic [3:0] md, input bit sv,
                             input logic [7:0] b);
    if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (st) begin
        q.delete();
        m_status = 4'h0; m_to = 1'b0; m_mode = md;
        if (md == 4'd1 || md == 4'd2 || md == 4'd3) begin
          m_phase = 1; m_idle = 0; m_skip = 1'b0; m_ext = 1'b0;
        end else begin
          model_finish(4'b0111, 1'b0);
        end
      end
    end else if (sv) begin
      m_idle = 0;
      if (m_skip) begin
        m_skip = 1'b0;
      end else if (m_ext) begin
        m_ext = 1'b0;
        if (b == 8'hF0) m_skip = 1'b1;
        else if (b == 8'h5A) model_key(b);
      end else if (b == 8'hF0) begin
        m_skip = 1'b1;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else begin
        model_key(b);
      end
    end else if (m_idle == int'(TO) - 1) begin
      model_finish(4'b0111, 1'b1);
    end else begin
      m_idle++;
    end
  endtask

  initial begin
    bit   early;
    int   n;
    int   quiet;
    int   r;
    bit   bad;

    vecs[0]  = '{"acc_basic",   4'd2, 7, 64'({8'h16,8'hF0,8'h16,8'h1E,8'hF0,8'h1E,8'h5A}), 1'b1, 4'b1000, 16'h0012, 3'd2};
    vecs[1]  = '{"pin_short",   4'd3, 4, 64'({8'h16,8'h1E,8'h26,8'h5A}),                     1'b0, 4'b0000, 16'h0123, 3'd3};
    vecs[2]  = '{"pin_full",    4'd3, 6, 64'({8'h16,8'h1E,8'h26,8'h5A,8'h25,8'h5A}),         1'b1, 4'b1000, 16'h1234, 3'd4};
    vecs[3]  = '{"pin_fifth",   4'd3, 6, 64'({8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h5A}),         1'b1, 4'b1000, 16'h1234, 3'd4};
    vecs[4]  = '{"acc_bksp",    4'd2, 5, 64'({8'h16,8'h1E,8'h66,8'h26,8'h5A}),               1'b1, 4'b1000, 16'h0013, 3'd2};
    vecs[5]  = '{"bksp_empty",  4'd2, 1, 64'({8'h66}),                                       1'b0, 4'b0000, 16'h0000, 3'd0};
    vecs[6]  = '{"ext_enter",   4'd2, 3, 64'({8'h45,8'hE0,8'h5A}),                           1'b1, 4'b1000, 16'h0000, 3'd1};
    vecs[7]  = '{"ext_break",   4'd2, 4, 64'({8'h45,8'hE0,8'hF0,8'h5A}),                     1'b0, 4'b0000, 16'h0000, 3'd1};
    vecs[8]  = '{"escape",      4'd2, 1, 64'({8'h76}),                                       1'b1, 4'b0111, 16'h0000, 3'd0};
    vecs[9]  = '{"single_8",    4'd1, 1, 64'({8'h3E}),                                       1'b1, 4'b1000, 16'h0008, 3'd1};
    vecs[10] = '{"single_ent",  4'd1, 2, 64'({8'h5A,8'h3E}),                                 1'b1, 4'b1000, 16'h0008, 3'd1};
    vecs[11] = '{"acc_esc_hold",4'd2, 3, 64'({8'h5A,8'h16,8'h76}),                           1'b1, 4'b0111, 16'h0001, 3'd1};
    vecs[12] = '{"bad_mode",    4'd5, 0, 64'h0,                                              1'b1, 4'b0111, 16'h0000, 3'd0};

    rst = 1'b1; scan_valid = 1'b0; scan_byte = 8'h00; start = 1'b0; mode = 4'h0;
    step(); step();
    chk("reset_busy",   32'(busy), 0);
    chk("reset_done",   32'(done), 0);
    chk("reset_value",  32'(value), 0);
    chk("reset_count",  32'(digit_count), 0);
    chk("reset_status", 32'(status), 0);
    chk("reset_to",     32'(timed_out), 0);
    rst = 1'b0;
    step();

    foreach (vecs[v]) begin
      early = 1'b0;
      begin_entry(vecs[v].mode);
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i > 0) begin
          step();
          early |= done;
        end
        send(vecs[v].seq[8*(vecs[v].n-1-i) +: 8]);
        if (i < vecs[v].n - 1) early |= done;
      end
      $display("vec %s mode=%0h done=%0b status=%0h value=%h count=%0d", vecs[v].name,
               vecs[v].mode, done, status, value, digit_count);
      chk({vecs[v].name, "_early"}, 32'(early), 0);
      chk({vecs[v].name, "_done"},  32'(done), 32'(vecs[v].exp_done));
      chk({vecs[v].name, "_value"}, 32'(value), 32'(vecs[v].exp_value));
      chk({vecs[v].name, "_count"}, 32'(digit_count), 32'(vecs[v].exp_count));
      if (vecs[v].exp_done) begin
        chk({vecs[v].name, "_status"}, 32'(status), 32'(vecs[v].exp_status));
        chk({vecs[v].name, "_to"}, 32'(timed_out), 0);
        step();
        chk({vecs[v].name, "_one_shot"}, 32'(done), 0);
        chk({vecs[v].name, "_busy_low"}, 32'(busy), 0);
        chk({vecs[v].name, "_held"}, 32'(value), 32'(vecs[v].exp_value));
      end else begin
        chk({vecs[v].name, "_busy"}, 32'(busy), 1);
        send(8'h76);
        chk({vecs[v].name, "_cleanup"}, 32'(done), 1);
        step();
      end
      step();
    end

    // Inactivity timeout: done exactly TO cycles after the last byte
    begin_entry(4'd2);
    send(8'h16);
    n = 0;
    while (!done && n < 100) begin step(); n++; end
    $display("seq timeout cycles=%0d status=%0h timed_out=%0b", n, status, timed_out);
    chk("timeout_latency", 32'(n), 50);
    chk("timeout_status",  32'(status), 32'b0111);
    chk("timeout_flag",    32'(timed_out), 1);
    chk("timeout_value",   32'(value), 32'h0001);
    step();

    // Byte in the would-be timeout cycle wins and restarts the timer
    begin_entry(4'd2);
    send(8'h16);
    repeat (49) step();
    send(8'h1E);
    chk("late_byte_no_done", 32'(done), 0);
    chk("late_byte_busy",    32'(busy), 1);
    chk("late_byte_count",   32'(digit_count), 2);
    n = 0;
    while (!done && n < 100) begin step(); n++; end
    $display("seq late_byte restart_cycles=%0d value=%h", n, value);
    chk("late_byte_restart", 32'(n), 50);
    chk("late_byte_value",   32'(value), 32'h0012);
    step();

    // start while busy keeps the original mode
    begin_entry(4'd2);
    mode = 4'd1; start = 1'b1; step(); start = 1'b0;
    send(8'h16);
    chk("busy_start_no_done", 32'(done), 0);
    chk("busy_start_count",   32'(digit_count), 1);
    send(8'h5A);
    $display("seq busy_start done=%0b value=%h", done, value);
    chk("busy_start_done",    32'(done), 1);
    chk("busy_start_value",   32'(value), 32'h0001);

    // start during the done cycle is ignored and results hold
    mode = 4'd2; start = 1'b1; step(); start = 1'b0;
    $display("seq done_start busy=%0b count=%0d", busy, digit_count);
    chk("done_start_busy",  32'(busy), 0);
    chk("done_start_count", 32'(digit_count), 1);
    step();
    chk("done_start_idle",  32'(busy), 0);

    // Reset mid-entry clears outputs without a clock edge and never strobes done
    begin_entry(4'd2);
    send(8'h16);
    send(8'h1E);
    rst = 1'b1;
    #2;
    $display("seq mid_reset busy=%0b value=%h count=%0d", busy, value, digit_count);
    chk("mid_reset_busy",  32'(busy), 0);
    chk("mid_reset_value", 32'(value), 0);
    chk("mid_reset_count", 32'(digit_count), 0);
    early = 1'b0;
    step(); early |= done;
    rst = 1'b0;
    step(); early |= done;
    step(); early |= done;
    chk("mid_reset_no_done", 32'(early), 0);

    // Random traffic against the reference model
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    quiet = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (quiet > 0) begin
        quiet--;
        scan_valid = 1'b0;
      end else begin
        scan_valid = ($urandom_range(0, 9) < 4);
        if ($urandom_range(0, 99) == 0) quiet = $urandom_range(40, 60);
      end
      scan_byte = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                              : pool[$urandom_range(0, 17)];
      start = (m_phase == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 19);
      mode = (r < 18) ? 4'(1 + r % 3) : 4'($urandom_range(0, 15));
      model_cycle(start, mode, scan_valid, scan_byte);
      step();
      bad = (busy !== (m_phase == 1)) || (done !== (m_phase == 2)) ||
            (value !== model_value()) || (digit_count !== 3'(q.size())) ||
            (status !== m_status) || (timed_out !== m_to);
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL rand_cycle%0d actual=b%0b d%0b v%h c%0d s%h t%0b required=b%0b d%0b v%h c%0d s%h t%0b",
                 cyc, busy, done, value, digit_count, status, timed_out,
                 m_phase == 1, m_phase == 2, model_value(), q.size(), m_status, m_to);
      end
      if (done) $display("rand cycle=%0d done status=%0h value=%h count=%0d to=%0b",
                         cyc, status, value, digit_count, timed_out);
    end
    scan_valid = 1'b0;
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
